ysyx_22050612_fetchq: RTL and testbench

Parametrised, decoupled instruction-fetch front end for the ysyx_22050612 core. It replaces the single-cycle fetch path with the following functions:
- a PC generator;
- an in-order memory request/response port with multiple outstanding requests;
- a DEPTH-entry prefetch queue feeding IDU through a valid/ready handshake.

A redirect input flushes the queue and all in-flight fetches. This lets EXU branches, jumps and traps steer fetch without stalling the memory port.

---
 rtl/ysyx_22050612_pkg.sv | 19 +
 rtl/ysyx_22050612_sync_fifo.sv | 61 ++++++
 rtl/ysyx_22050612_fetchq.sv | 125 ++++++++++++
 tb/tb_ysyx_22050612_fetchq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050612_pkg.sv
// ysyx_22050612_pkg
// Shared constants for the ysyx_22050612 fetch front end.
//   XLEN_DEFAULT     : default PC / address width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   ILEN             : instruction word width
//   PC_STEP          : byte distance between sequential fetches
package ysyx_22050612_pkg;

    localparam int          XLEN_DEFAULT     = 64;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam int          ILEN             = 32;
    localparam int          PC_STEP          = 4;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ysyx_22050612_sync_fifo.sv
// ysyx_22050612_sync_fifo
// Single-clock FIFO with a synchronous flush, used as the prefetch queue.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset (control only)
//   flush           : empty the queue and reset both pointers this cycle
//   push, push_data : write push_data at the tail
//   pop             : drop the head entry
//   head_data       : head entry, forced to zero while the queue is empty
//   count           : number of valid entries, 0..DEPTH
module ysyx_22050612_sync_fifo
    import ysyx_22050612_pkg::*;
#(
    parameter  int DATA_W = 96,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= push_data;
    end

    // Gating on count keeps the outputs at zero after reset and after a flush.
    assign head_data = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/ysyx_22050612_fetchq.sv
// ysyx_22050612_fetchq
// Decoupled instruction-fetch front end: PC generator, in-order memory port
// with up to DEPTH outstanding requests, and a DEPTH-entry prefetch queue.
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr  : fetch request to memory (4-byte aligned)
//   resp_valid/resp_inst          : in-order responses, never back-pressured
//   redir_valid/redir_pc          : redirect; flushes queue and in-flight fetches
//   inst_valid/inst_ready         : queue head handshake toward IDU
//   inst/inst_pc                  : head instruction and its PC
module ysyx_22050612_fetchq
    import ysyx_22050612_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [ILEN-1:0] resp_inst,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int SUM_W = CNT_W + 1;

    logic [XLEN-1:0]      pc_q;
    logic [XLEN-1:0]      enq_pc;
    logic [CNT_W-1:0]     live;
    logic [CNT_W-1:0]     drop;
    logic                 started;
    logic [CNT_W-1:0]     count;
    logic [XLEN-1:0]      redir_tgt;
    logic                 credit_ok;
    logic                 req_fire;
    logic                 resp_drop;
    logic                 resp_keep;
    logic                 resp_take;
    logic                 push;
    logic                 pop;
    logic [XLEN+ILEN-1:0] head_data;
    logic                 unused_redir_lsb;

    function automatic logic [SUM_W-1:0] widen(input logic [CNT_W-1:0] v);
        return {1'b0, v};
    endfunction

    assign redir_tgt        = {redir_pc[XLEN-1:2], 2'b00};
    assign unused_redir_lsb = ^redir_pc[1:0];

    // Credits: every kept response needs a queue slot, and the memory never
    // sees more than DEPTH requests in flight, kept or discarded.
    assign credit_ok = (widen(live) + widen(count) < SUM_W'(DEPTH)) &&
                       (widen(live) + widen(drop)  < SUM_W'(DEPTH));

    assign req_valid = started && !redir_valid && credit_ok;
    assign req_addr  = pc_q;
    assign req_fire  = req_valid && req_ready;

    // Responses owed to a flushed fetch are retired first; a response with
    // no owner at all is a protocol error and simply ignored.
    assign resp_drop = resp_valid && (drop != '0);
    assign resp_keep = resp_valid && (drop == '0) && (live != '0);
    assign resp_take = resp_drop || resp_keep;
    assign push      = resp_keep && !redir_valid;

    assign inst_valid = (count != '0) && !redir_valid;
    assign pop        = inst_valid && inst_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            enq_pc  <= RESET_PC;
            live    <= '0;
            drop    <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redir_valid) begin
                // Everything still in flight becomes discard credit, minus the
                // response (if any) retired in this very cycle.
                pc_q   <= redir_tgt;
                enq_pc <= redir_tgt;
                live   <= '0;
                drop   <= drop + live - CNT_W'(resp_take);
            end else begin
                if (req_fire) pc_q   <= pc_q + XLEN'(PC_STEP);
                if (push)     enq_pc <= enq_pc + XLEN'(PC_STEP);
                live <= live + CNT_W'(req_fire) - CNT_W'(resp_keep);
                if (resp_drop) drop <= drop - CNT_W'(1);
            end
        end
    end

    ysyx_22050612_sync_fifo #(
        .DATA_W (XLEN + ILEN),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redir_valid),
        .push      (push),
        .push_data ({enq_pc, resp_inst}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    assign inst_pc = head_data[XLEN+ILEN-1:ILEN];
    assign inst    = head_data[ILEN-1:0];

    resp_has_owner: assert property (
        @(posedge clk) disable iff (!rst) resp_valid |-> (live != '0 || drop != '0)
    );

endmodule

// File: tb/tb_ysyx_22050612_fetchq.sv
module tb_ysyx_22050612_fetchq;
    import ysyx_22050612_pkg::*;

    localparam int          XLEN   = 64;
    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [31:0]     resp_inst;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;

    ysyx_22050612_fetchq #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_inst   (resp_inst),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [63:0] target;
        int          lat;
        longint      wait_hs;
        logic        resp_at_redir;
        logic [63:0] pc0;
        logic [63:0] pc1;
    } vec_t;

    mreq_t       memq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          ready_pct = 100;
    int          iready_pct = 100;
    bit          chk_en = 0;

    // Reference model: expected next request address and next delivered PC.
    logic [63:0] exp_req;
    logic [63:0] exp_pop;
    longint      hs_total, resp_total, pop_total;
    logic        prev_pend;
    logic [63:0] prev_addr;

    logic        s_req_valid, s_req_ready, s_inst_valid, s_redir, s_resp, s_pop, s_hs;
    logic [63:0] s_req_addr, s_inst_pc, s_rpc;
    logic [31:0] s_inst;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // One clock cycle: sample at negedge, run the model, advance the memory.
    task automatic cycle();
        @(negedge clk);
        s_req_valid  = req_valid;
        s_req_ready  = req_ready;
        s_req_addr   = req_addr;
        s_inst_valid = inst_valid;
        s_inst_pc    = inst_pc;
        s_inst       = inst;
        s_redir      = redir_valid;
        s_rpc        = redir_pc;
        s_resp       = resp_valid;
        s_pop        = inst_valid && inst_ready;
        s_hs         = req_valid && req_ready;
        if (s_hs)   hs_total++;
        if (s_resp) resp_total++;
        if (s_pop)  pop_total++;
        if (chk_en) begin
            chk("outstanding_bound", (hs_total - resp_total <= DEPTH) ? 64'd1 : 64'd0, 64'd1);
            if (prev_pend && !s_redir) begin
                chk("stall_req_valid", s_req_valid, 1);
                chk("stall_req_addr", s_req_addr, prev_addr);
            end
            if (s_redir) begin
                chk("redir_req_valid", s_req_valid, 0);
                chk("redir_inst_valid", s_inst_valid, 0);
                exp_req = {s_rpc[63:2], 2'b00};
                exp_pop = {s_rpc[63:2], 2'b00};
            end else begin
                if (s_hs) begin
                    chk("req_addr", s_req_addr, exp_req);
                    exp_req = exp_req + 64'd4;
                end
                if (s_pop) begin
                    chk("pop_pc", s_inst_pc, exp_pop);
                    chk("pop_inst", s_inst, mem_word(exp_pop));
                    exp_pop = exp_pop + 64'd4;
                end
            end
        end
        prev_pend = s_req_valid && !s_req_ready && !s_redir;
        prev_addr = s_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (s_hs) memq.push_back('{addr: s_req_addr, due: cyc + lat - 1});
        resp_valid = 1'b0;
        resp_inst  = '0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_inst  = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end
        req_ready  = ($urandom_range(99) < ready_pct);
        inst_ready = ($urandom_range(99) < iready_pct);
    endtask

    task automatic do_reset();
        chk_en      = 0;
        rst         = 1'b0;
        redir_valid = 1'b0;
        resp_valid  = 1'b0;
        resp_inst   = '0;
        memq.delete();
        #1;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_req_addr", req_addr, RST_PC);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        repeat (2) @(posedge clk);
        #1;
        exp_req    = RST_PC;
        exp_pop    = RST_PC;
        hs_total   = 0;
        resp_total = 0;
        pop_total  = 0;
        prev_pend  = 1'b0;
        rst        = 1'b1;
        chk_en     = 1;
    endtask

    task automatic run_until_hs(input longint n);
        for (int k = 0; k < 40 && hs_total < n; k++) cycle();
        chk("wait_req_count", hs_total, n);
    endtask

    task automatic wait_pop(input string name, output logic [63:0] pc, output logic [31:0] w);
        bit got;
        got = 0;
        pc  = '0;
        w   = '0;
        for (int k = 0; k < 40 && !got; k++) begin
            cycle();
            if (s_pop) begin
                got = 1;
                pc  = s_inst_pc;
                w   = s_inst;
            end
        end
        chk({name, "_arrived"}, got, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        vec_t        vecs[5];
        logic        rv[8];
        logic        iv[8];
        logic [63:0] pcs[8];
        logic [63:0] pc;
        logic [31:0] w;

        vecs[0] = '{64'h0000_0000_8000_1002, 3, 3, 1'b1, 64'h0000_0000_8000_1000, 64'h0000_0000_8000_1004};
        vecs[1] = '{64'h0000_0000_0000_0007, 1, 2, 1'b1, 64'h0000_0000_0000_0004, 64'h0000_0000_0000_0008};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
        vecs[3] = '{64'h1234_5678_9ABC_DEF1, 1, 5, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF4};
        vecs[4] = '{64'h0000_0000_8000_0000, 3, 4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0004};

        rst         = 1'b1;
        req_ready   = 1'b1;
        inst_ready  = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = '0;
        resp_valid  = 1'b0;
        resp_inst   = '0;
        #2;

        // Reset release, 1-cycle memory, always ready
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle();
            rv[i]  = s_req_valid;
            iv[i]  = s_inst_valid;
            pcs[i] = s_inst_pc;
        end
        chk("t1_req_valid_c0", rv[0], 0);
        chk("t1_req_valid_c1", rv[1], 1);
        chk("t1_inst_valid_c2", iv[2], 0);
        for (int i = 3; i < 8; i++) chk("t1_inst_valid_stream", iv[i], 1);
        chk("t1_pc0", pcs[3], 64'h8000_0000);
        chk("t1_pc1", pcs[4], 64'h8000_0004);
        chk("t1_pc2", pcs[5], 64'h8000_0008);

        // IDU stalled: queue fills, requests stop at DEPTH
        iready_pct = 0;
        inst_ready = 1'b0;
        do_reset();
        repeat (15) cycle();
        chk("t2_req_count", hs_total, DEPTH);
        chk("t2_req_valid_full", s_req_valid, 0);
        chk("t2_inst_valid_full", s_inst_valid, 1);
        iready_pct = 100;
        inst_ready = 1'b1;
        cycle();
        chk("t2_first_pop", s_pop, 1);
        cycle();
        chk("t2_req_after_pop", s_req_valid, 1);
        repeat (6) cycle();

        // Table of redirect scenarios
        for (int v = 0; v < 5; v++) begin
            lat = vecs[v].lat;
            do_reset();
            run_until_hs(vecs[v].wait_hs);
            redir_valid = 1'b1;
            redir_pc    = vecs[v].target;
            cycle();
            chk("tv_resp_in_redir", s_resp, vecs[v].resp_at_redir);
            chk("tv_no_req_in_redir", s_hs, 0);
            redir_valid = 1'b0;
            wait_pop("tv_first", pc, w);
            chk("tv_first_pc", pc, vecs[v].pc0);
            chk("tv_first_inst", w, mem_word(vecs[v].pc0));
            wait_pop("tv_second", pc, w);
            chk("tv_second_pc", pc, vecs[v].pc1);
            chk("tv_second_inst", w, mem_word(vecs[v].pc1));
        end

        // Back-to-back redirects: the later one wins
        lat = 2;
        do_reset();
        run_until_hs(2);
        redir_valid = 1'b1;
        redir_pc    = 64'h100;
        cycle();
        redir_pc    = 64'h200;
        cycle();
        redir_valid = 1'b0;
        wait_pop("b2b", pc, w);
        chk("b2b_first_pc", pc, 64'h200);
        chk("b2b_first_inst", w, 32'h200);

        // Asynchronous reset with data queued and requests in flight
        lat        = 3;
        iready_pct = 0;
        inst_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 30 && !(s_inst_valid && (hs_total - resp_total >= 2)); k++) cycle();
        chk("t6_queued_before_reset", inst_valid, 1);
        do_reset();
        iready_pct = 100;
        inst_ready = 1'b1;
        wait_pop("t6_restart", pc, w);
        chk("t6_restart_pc", pc, RST_PC);
        chk("t6_restart_inst", w, mem_word(RST_PC));

        // Randomised traffic against the reference model
        ready_pct  = 80;
        iready_pct = 70;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            lat = int'($urandom_range(3, 1));
            if ($urandom_range(19) == 0) begin
                redir_valid = 1'b1;
                if ($urandom_range(3) == 0) redir_pc = {32'hFFFF_FFFF, $urandom};
                else                        redir_pc = {$urandom, $urandom};
            end else begin
                redir_valid = 1'b0;
            end
            cycle();
        end
        redir_valid = 1'b0;
        chk("rand_progress", (pop_total > 200) ? 64'd1 : 64'd0, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
